// File: rtl/ram_share_arbiter_if.sv
// Requester-side bus of the shared scratch RAM: two request ports plus the read-data return.
// Optional lock0/lock1 exist only when RAM_SHARE_ARBITER_LOCK_EN is defined.
`timescale 1ns/1ps
interface ram_share_arbiter_if #(
  parameter int A = 5,
  parameter int D = 4
);
  logic         req0;
  logic         we0;
  logic [A-1:0] addr0;
  logic [D-1:0] din0;
  logic         gnt0;
  logic         req1;
  logic         we1;
  logic [A-1:0] addr1;
  logic [D-1:0] din1;
  logic         gnt1;
  logic [D-1:0] rdata;
`ifdef RAM_SHARE_ARBITER_LOCK_EN
  logic         lock0;
  logic         lock1;
`endif

  modport master (
    output req0, we0, addr0, din0,
    output req1, we1, addr1, din1,
`ifdef RAM_SHARE_ARBITER_LOCK_EN
    output lock0, lock1,
`endif
    input  gnt0, gnt1, rdata
  );

  modport slave (
    input  req0, we0, addr0, din0,
    input  req1, we1, addr1, din1,
`ifdef RAM_SHARE_ARBITER_LOCK_EN
    input  lock0, lock1,
`endif
    output gnt0, gnt1, rdata
  );
endinterface

// File: rtl/ram_share_arbiter.sv
// Owns the single port of the scratch RAM: zero-sweeps it after reset / clr_start, then
// grants one access per clock round-robin. Optional owner lock: RAM_SHARE_ARBITER_LOCK_EN.
`timescale 1ns/1ps
module ram_share_arbiter #(
  parameter int A = 5,
  parameter int D = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_start_i,
  output logic                clr_busy_o,
  ram_share_arbiter_if.slave  req_if,
  output logic [A-1:0]        mem_addr_o,
  output logic [D-1:0]        mem_din_o,
  output logic                mem_we_o,
  input  logic [D-1:0]        mem_dout_i
);

  localparam logic [0:0]   CLEAR   = 1'b0;
  localparam logic [0:0]   ARB     = 1'b1;
  localparam logic [A-1:0] CNT_MAX = '1;

  logic [0:0]   mode_q, mode_d;
  logic [A-1:0] cnt_q, cnt_d;
  logic         prio_q, prio_d;
  logic [A-1:0] last_addr_q;
  logic         gnt0, gnt1;
  logic         clr_req;

`ifdef RAM_SHARE_ARBITER_LOCK_EN
  logic own_q, own_d;
  logic owner_q, owner_d;
  logic pend_q, pend_d;
  logic hold;

  // The owner keeps the port only while it still presents both req and lock.
  assign hold    = own_q && (owner_q ? (req_if.req1 && req_if.lock1)
                                     : (req_if.req0 && req_if.lock0));
  assign clr_req = clr_start_i || pend_q;
`else
  assign clr_req = clr_start_i;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (mode_q == ARB) begin
      if (req_if.req0 && req_if.req1) begin
        gnt0 = !prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req_if.req0;
        gnt1 = req_if.req1;
      end
`ifdef RAM_SHARE_ARBITER_LOCK_EN
      if (hold) begin
        gnt0 = !owner_q;
        gnt1 = owner_q;
      end
`endif
    end
  end

  always_comb begin
    mem_we_o   = 1'b1;
    mem_addr_o = cnt_q;
    mem_din_o  = '0;
    if (mode_q == ARB) begin
      mem_we_o   = 1'b0;
      mem_addr_o = last_addr_q;
      if (gnt1) begin
        mem_we_o   = req_if.we1;
        mem_addr_o = req_if.addr1;
        mem_din_o  = req_if.din1;
      end else if (gnt0) begin
        mem_we_o   = req_if.we0;
        mem_addr_o = req_if.addr0;
        mem_din_o  = req_if.din0;
      end
    end
  end

  assign req_if.gnt0  = gnt0;
  assign req_if.gnt1  = gnt1;
  assign req_if.rdata = mem_dout_i;
  assign clr_busy_o   = (mode_q == CLEAR);

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    prio_d = prio_q;
`ifdef RAM_SHARE_ARBITER_LOCK_EN
    own_d   = 1'b0;
    owner_d = owner_q;
    pend_d  = pend_q;
`endif
    if (mode_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX) begin
        mode_d = ARB;
        cnt_d  = '0;
      end
    end else begin
      // While a lock is held the owner is re-granted, so prio already points at the other port on release.
      if (gnt0 || gnt1) prio_d = gnt0;
`ifdef RAM_SHARE_ARBITER_LOCK_EN
      own_d   = (gnt0 && req_if.lock0) || (gnt1 && req_if.lock1);
      owner_d = gnt1;
      if (clr_req && own_d) begin
        pend_d = 1'b1;
      end else if (clr_req) begin
        mode_d = CLEAR;
        cnt_d  = '0;
        prio_d = 1'b0;
        pend_d = 1'b0;
      end
`else
      if (clr_req) begin
        mode_d = CLEAR;
        cnt_d  = '0;
        prio_d = 1'b0;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= CLEAR;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      last_addr_q <= '0;
`ifdef RAM_SHARE_ARBITER_LOCK_EN
      own_q       <= 1'b0;
      owner_q     <= 1'b0;
      pend_q      <= 1'b0;
`endif
    end else begin
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      last_addr_q <= mem_addr_o;
`ifdef RAM_SHARE_ARBITER_LOCK_EN
      own_q       <= own_d;
      owner_q     <= owner_d;
      pend_q      <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Self-checking bench for ram_share_arbiter: behavioural RAM, scoreboard of expected grants
// in order, direct checks of reset and sweep behaviour.
`timescale 1ns/1ps
module tb_ram_share_arbiter;
  localparam int A     = 5;
  localparam int D     = 4;
  localparam int DEPTH = 1 << A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clr_start = 1'b0;
  logic         clr_busy;
  logic [A-1:0] mem_addr;
  logic [D-1:0] mem_din;
  logic [D-1:0] mem_dout;
  logic         mem_we;

  logic [D-1:0] ram     [DEPTH];
  logic [D-1:0] ref_mem [DEPTH];

  ram_share_arbiter_if #(.A(A), .D(D)) bus ();

  ram_share_arbiter #(.A(A), .D(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_start_i (clr_start),
    .clr_busy_o  (clr_busy),
    .req_if      (bus.slave),
    .mem_addr_o  (mem_addr),
    .mem_din_o   (mem_din),
    .mem_we_o    (mem_we),
    .mem_dout_i  (mem_dout)
  );

  always #5 clk = ~clk;

  assign mem_dout = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_din;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic         port;
    logic         we;
    logic [A-1:0] addr;
    logic [D-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic push_exp(input logic port, input logic we, input logic [A-1:0] addr,
                          input logic [D-1:0] din);
    exp_t e;
    e.port = port;
    e.we   = we;
    e.addr = addr;
    if (we) begin
      ref_mem[addr] = din;
      e.data = din;
    end else begin
      e.data = ref_mem[addr];
    end
    exp_q.push_back(e);
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Scoreboard: every grant must match the oldest expected access.
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'(0));
      if (!clr_busy) check("we_without_gnt", 32'(mem_we & ~(bus.gnt0 | bus.gnt1)), 32'(0));
      if (bus.gnt0 || bus.gnt1) begin
        check("sb_unexpected_gnt", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("gnt_port", 32'(bus.gnt1), 32'(mon_e.port));
          check("gnt_addr", 32'(mem_addr), 32'(mon_e.addr));
          check("gnt_we", 32'(mem_we), 32'(mon_e.we));
          if (mon_e.we) check("wr_data", 32'(mem_din), 32'(mon_e.data));
          else          check("rd_data", 32'(bus.rdata), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [A-1:0] addr, input logic [D-1:0] din);
    if (p == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.din0 = din;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.din1 = din;
    end
  endtask

  // Starts and ends just after a rising edge; drops the request the cycle after its grant.
  task automatic access(input int p, input logic we, input logic [A-1:0] addr,
                        input logic [D-1:0] din, input logic clr);
    logic got;
    got = 1'b0;
    push_exp(p[0], we, addr, din);
    set_port(p, 1'b1, we, addr, din);
    clr_start = clr;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? bus.gnt0 : bus.gnt1;
      if (!got) tick();
    end
    check("access_timeout", 32'(got), 32'(1));
    tick();
    set_port(p, 1'b0, 1'b0, '0, '0);
    clr_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    #1;
    check("rst_clr_busy", 32'(clr_busy), 32'(1));
    check("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(1));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_din", 32'(mem_din), 32'(0));
    tick();
    tick();
    rst_n = 1'b1;
    clear_ref();
  endtask

  // Checks the full sweep starting at cycle 0; ends at the falling edge of cycle DEPTH.
  task automatic sweep_check(input bit pulse_mid, input bit req_cyc3);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      check("sweep_busy", 32'(clr_busy), 32'(1));
      check("sweep_we", 32'(mem_we), 32'(1));
      check("sweep_addr", 32'(mem_addr), 32'(k));
      check("sweep_din", 32'(mem_din), 32'(0));
      if (req_cyc3 && k >= 3) check("sweep_gnt0_held_off", 32'(bus.gnt0), 32'(0));
      tick();
      clr_start = pulse_mid && (k == 9);
      if (req_cyc3 && k + 1 == 3) begin
        push_exp(1'b0, 1'b0, A'(12), '0);
        set_port(0, 1'b1, 1'b0, A'(12), '0);
      end
    end
    clr_start = 1'b0;
    @(negedge clk);
    check("sweep_done_busy", 32'(clr_busy), 32'(0));
    check("sweep_done_we", 32'(mem_we), 32'(0));
    if (req_cyc3) check("held_req_gnt0", 32'(bus.gnt0), 32'(1));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 4'hF;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
`ifdef RAM_SHARE_ARBITER_LOCK_EN
    bus.lock0 = 1'b0;
    bus.lock1 = 1'b0;
`endif

    // Reset, sweep with no requests, then read the whole RAM back.
    do_reset();
    sweep_check(1'b0, 1'b0);
    tick();
    for (int a = 0; a < DEPTH; a++) access(0, 1'b0, A'(a), '0, 1'b0);

    // Write on port 1 then read-after-write on port 0 in the next cycle.
    access(1, 1'b1, A'(5), 4'hA, 1'b0);
    access(0, 1'b0, A'(5), '0, 1'b0);
    access(1, 1'b1, A'(12), 4'h9, 1'b0);

    // clr_start alongside a write; second clr_start mid-sweep must not extend it.
    access(1, 1'b1, A'(7), 4'h3, 1'b1);
    clear_ref();
    sweep_check(1'b1, 1'b0);
    tick();

    // Continuous contention after a fresh clear: strict alternation 0,1,0,1,0,1.
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) push_exp(1'b0, 1'b0, A'(7), '0);
      else            push_exp(1'b1, 1'b0, A'(5), '0);
    end
    set_port(0, 1'b1, 1'b0, A'(7), '0);
    set_port(1, 1'b1, 1'b0, A'(5), '0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tick();
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);

`ifdef RAM_SHARE_ARBITER_LOCK_EN
    // Port 0 locks for 4 cycles against a waiting port 1, then alternation resumes with port 0.
    for (int c = 0; c < 7; c++) begin
      if (c == 4 || c == 6) push_exp(1'b1, 1'b0, A'(3), '0);
      else                  push_exp(1'b0, 1'b1, A'(3), 4'h6);
    end
    for (int c = 0; c < 7; c++) begin
      set_port(0, c <= 5, 1'b1, A'(3), 4'h6);
      bus.lock0 = (c < 4);
      set_port(1, 1'b1, 1'b0, A'(3), '0);
      @(negedge clk);
      tick();
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    bus.lock0 = 1'b0;
`endif

    // Reset part-way through a sweep restarts it at address 0; a request raised in
    // cycle 3 is held off until the sweep ends and then reads the cleared word.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("partial_sweep_addr", 32'(mem_addr), 32'(k));
      tick();
    end
    do_reset();
    sweep_check(1'b0, 1'b1);
    tick();
    set_port(0, 1'b0, 1'b0, '0, '0);
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ram_share_arbiter.md
Name: ram_share_arbiter

Overview:
- Owns the single port of the 32x4 async-read scratch RAM and shares it between two requesters: port 0 (solver core) and port 1 (external loader/debug).
- After reset, and on command, sweeps every RAM word to zero.
- Then arbitrates round-robin with one access per clock.
- Sits directly between requesters and RAM; no requester drives the RAM directly.

Parameters:
A, 5, RAM address width (depth = 1<<A)
D, 4, RAM data width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr_start  input  1  pulse: start a full-RAM zero sweep (ignored while sweeping)
clr_busy  output  1  high while sweep in progress
req0  input  1  port 0 access request, held until granted
we0  input  1  port 0 write (1) / read (0)
addr0  input  A  port 0 address
din0  input  D  port 0 write data
gnt0  output  1  port 0 granted this cycle (combinational)
req1, we1, addr1, din1, gnt1  as port 0, for port 1
rdata  output  D  read data = mem_dout, valid in the granted cycle
mem_addr  output  A  to RAM addr
mem_din  output  D  to RAM din
mem_we  output  1  to RAM we
mem_dout  input  D  from RAM dout (async read)

Behaviour:
- State: mode {CLEAR, ARB}, sweep counter cnt[A-1:0], priority pointer prio (0 = port 0 wins a tie).
- Reset (rst_n=0, asynchronous): mode=CLEAR, cnt=0, prio=0.
  - Outputs while held in reset: clr_busy=1, gnt0=gnt1=0, mem_we=1, mem_addr=0, mem_din=0 (repeated zero write to addr 0 is intended).
- CLEAR:
  - mem_we=1, mem_addr=cnt, mem_din=0, clr_busy=1, gnt0=gnt1=0.
  - cnt increments each clock.
  - On the edge where cnt==(1<<A)-1: mode->ARB, cnt->0.
  - Sweep writes addr k in cycle k after reset release: exactly 1<<A cycles (32 at default). clr_busy falls in cycle 32.
  - Requests are held off (not dropped) for the whole sweep.
- ARB, per cycle, combinational grant:
  - Only one of req0/req1 high: that port is granted.
  - Both high: port prio is granted.
  - Neither high: no grant, mem_we=0, mem_addr holds last value driven (registered mux select; no functional dependency).
  - The granted port drives mem_addr/mem_din, and mem_we = its we bit.
  - rdata=mem_dout in the same cycle; a write completes at the closing clock edge.
- Priority update:
  - On any granted cycle, prio <- index of the port NOT granted. Alternation is strict under continuous contention.
  - No grant: prio unchanged.
- Requester rule: hold req/we/addr/din stable until gnt seen high, then drop or present the next request in the following cycle. Back-to-back single-port accesses get one grant per cycle.
- clr_start:
  - Sampled only in ARB. The current cycle's arbitration and access still complete.
  - mode->CLEAR and cnt->0 at that edge; prio reset to 0.
  - Ignored in CLEAR; does not restart the sweep.
- Read-after-write to the same address: a read granted the cycle after a write returns the new data.
- Reset mid-sweep or mid-access: abandons everything immediately; the sweep restarts at addr 0 after release.
- gnt0 and gnt1 are never high together. mem_we is never high in ARB without a grant.

Optional Feature:
RAM_SHARE_ARBITER_LOCK_EN
- Defined: adds inputs lock0/lock1 (1 bit each).
  - A granted port that holds its lock high keeps exclusive ownership in subsequent cycles. The other port is not granted even if prio favours it.
  - Ownership releases in the first cycle the owner's req or lock is low.
  - prio is updated only at release.
  - clr_start is deferred (latched) until release.
  - Use case: atomic read-modify-write by the solver.
- Undefined: no lock ports; pure per-cycle round-robin as above.

Test Plan:
- Reset release with both req low -> clr_busy=1 for 32 cycles, mem_we=1 with mem_addr 0..31 and mem_din=0; cycle 32: clr_busy=0, mem_we=0. Reading all 32 addresses via port 0 returns 0.
- After clear: port 1 writes addr 5 = 4'hA, next cycle port 0 reads addr 5 -> gnt1 then gnt0, rdata=4'hA in the read cycle.
- req0 and req1 held high 6 cycles from fresh reset/clear -> grants 0,1,0,1,0,1; no cycle with both gnt high.
- req0 asserted at cycle 3 after reset release -> gnt0 stays 0 until cycle 32, granted in cycle 32, request data unchanged.
- clr_start with req1 write addr 7 = 4'h3 in the same ARB cycle -> gnt1 that cycle, then 32-cycle sweep; subsequent read of addr 7 returns 0. A second clr_start mid-sweep does not extend clr_busy.
- LOCK_EN: port 0 granted with lock0=1 for 4 cycles while req1 high -> gnt0 four cycles, gnt1 the cycle lock0 drops, then alternation resumes starting with port 0.
